// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: FSM encoding,
// default boot address and the redirect alignment helper.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_3000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid register holding a fetched word (data, pc, valid) while decode stalls.
// Load takes effect on the next edge; drop wins over load.
module fetch_skid (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        drop,
    input  logic [31:0] load_dat,
    input  logic [31:0] load_pc,
    output logic        skid_vld,
    output logic [31:0] skid_dat,
    output logic [31:0] skid_pc
);

    logic        vld_q, vld_d;
    logic [31:0] dat_q, dat_d;
    logic [31:0] pc_q,  pc_d;

    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        pc_d  = pc_q;
        if (drop) begin
            vld_d = 1'b0;
        end else if (load) begin
            vld_d = 1'b1;
            dat_d = load_dat;
            pc_d  = load_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= 1'b0;
            dat_q <= 32'd0;
            pc_q  <= 32'd0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
            pc_q  <= pc_d;
        end
    end

    assign skid_vld = vld_q;
    assign skid_dat = dat_q;
    assign skid_pc  = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request, one output buffer
// plus a skid entry; 1-cycle ack-to-inst latency, redirect flushes everything.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        id_stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  addr_q, addr_d;
    logic         req_q, req_d;
    logic         inst_valid_q, inst_valid_d;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  inst_pc_q, inst_pc_d;

    logic         skid_load, skid_drop, skid_vld;
    logic [31:0]  skid_dat, skid_pc;
    logic         buf_free;
    logic [31:0]  pc_inc, tgt;

    fetch_skid u_skid (
        .clk      (clk),
        .rst      (rst),
        .load     (skid_load),
        .drop     (skid_drop),
        .load_dat (imem_rdata),
        .load_pc  (pc_q),
        .skid_vld (skid_vld),
        .skid_dat (skid_dat),
        .skid_pc  (skid_pc)
    );

    always_comb begin
        buf_free     = !inst_valid_q || !id_stall;
        pc_inc       = pc_q + 32'd4;
        tgt          = word_align(redirect_pc);
        state_d      = state_q;
        pc_d         = pc_q;
        inst_valid_d = inst_valid_q && id_stall;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        skid_load    = 1'b0;
        skid_drop    = 1'b0;

        case (state_q)
            ST_FETCH: begin
                if (redirect) begin
                    pc_d         = tgt;
                    inst_valid_d = 1'b0;
                    if (!imem_ack) state_d = ST_DRAIN;
                end else if (imem_ack) begin
                    pc_d = pc_inc;
                    if (buf_free) begin
                        inst_d       = imem_rdata;
                        inst_pc_d    = pc_q;
                        inst_valid_d = 1'b1;
                    end else begin
                        skid_load = 1'b1;
                        state_d   = ST_HOLD;
                    end
                end
            end
            ST_DRAIN: begin
                if (redirect) begin
                    pc_d         = tgt;
                    inst_valid_d = 1'b0;
                end
                if (imem_ack) state_d = ST_FETCH;
            end
            ST_HOLD: begin
                if (redirect) begin
                    skid_drop    = 1'b1;
                    pc_d         = tgt;
                    inst_valid_d = 1'b0;
                    state_d      = ST_FETCH;
                end else if (buf_free && skid_vld) begin
                    inst_d       = skid_dat;
                    inst_pc_d    = skid_pc;
                    inst_valid_d = 1'b1;
                    skid_drop    = 1'b1;
                    state_d      = ST_FETCH;
                end
            end
            default: begin
                skid_drop = 1'b1;
                state_d   = ST_FETCH;
            end
        endcase

        // The bus address stays frozen while a request is still waiting for its ack.
        addr_d = (req_q && !imem_ack) ? addr_q : pc_d;
        req_d  = (state_d == ST_FETCH) || (state_d == ST_DRAIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC;
            addr_q       <= RESET_PC;
            req_q        <= 1'b1;
            inst_valid_q <= 1'b0;
            inst_q       <= 32'd0;
            inst_pc_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            addr_q       <= addr_d;
            req_q        <= req_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = addr_q;
    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;

endmodule
